multicycle_control_unit: RTL and testbench

- Parametrised successor to the single-cycle CPU control unit.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states instead of decoding in one cycle.
- Handshakes with instruction/data memory and detects illegal opcodes and memory timeouts.
- Sits between the instruction register, register file, ALU and memory of the 8-bit CPU.

---
 rtl/cpu_ctrl_pkg.sv | 41 ++++
 rtl/ctrl_wait_timer.sv | 30 +++
 rtl/multicycle_control_unit.sv | 163 ++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the multicycle CPU control unit:
// FSM state encoding, opcode map and ALU function codes.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_ADD   = 3'd1;
    localparam logic [2:0] OP_SUB   = 3'd2;
    localparam logic [2:0] OP_AND   = 3'd3;
    localparam logic [2:0] OP_LOAD  = 3'd4;
    localparam logic [2:0] OP_STORE = 3'd5;
    localparam logic [2:0] OP_JMP   = 3'd6;
    localparam logic [2:0] OP_HALT  = 3'd7;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_AND  = 3'd2;
    localparam logic [2:0] ALU_PASS = 3'd3;

    // ALU function for a latched opcode; memory ops pass the address through.
    function automatic logic [2:0] alu_sel(input logic [2:0] op);
        logic [2:0] sel;
        case (op)
            OP_ADD:             sel = ALU_ADD;
            OP_SUB:             sel = ALU_SUB;
            OP_AND:             sel = ALU_AND;
            OP_LOAD, OP_STORE:  sel = ALU_PASS;
            default:            sel = ALU_ADD;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// Memory wait counter: counts stalled request cycles and flags when the
// count has reached the timeout limit.
module ctrl_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [7:0] wait_cnt_r;

    // Clear wins over counting; the count saturates at the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_r <= 8'd0;
        end else if (clear) begin
            wait_cnt_r <= 8'd0;
        end else if (enable && !expired) begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    assign expired = (wait_cnt_r == 8'(MEM_TIMEOUT));

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle control unit for the 8-bit CPU: sequences each instruction
// through FETCH/DECODE/EXEC/MEM/WB with memory handshake and timeout.
module multicycle_control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned OPCODE_W    = 3,
    parameter int unsigned ALU_OP_W    = 3,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                En,
    input  logic [OPCODE_W-1:0] Opcode,
    input  logic                Mem_ready,
    output logic                Mem_req,
    output logic                Ir_load,
    output logic                Pc_inc,
    output logic                Pc_load,
    output logic                En_write_reg,
    output logic                En_write_mem,
    output logic [ALU_OP_W-1:0] ALU_OP,
    output logic                Halted,
    output logic                Illegal_op,
    output logic                Bus_error
);

    localparam logic [OPCODE_W-1:0] LOW_MASK = OPCODE_W'(3'd7);

    state_t     state_r;
    state_t     state_next_s;
    logic [2:0] op_q_r;
    logic       bus_error_r;

    logic       opcode_illegal_s;
    logic [2:0] opcode_low_s;
    logic       run_s;
    logic       in_mem_phase_s;
    logic       timer_clear_s;
    logic       timer_enable_s;
    logic       timer_expired_s;
    logic       timed_out_s;
    logic [2:0] alu_s;

    assign opcode_illegal_s = |(Opcode & ~LOW_MASK);
    assign opcode_low_s     = Opcode[2:0];
    assign run_s            = En && !Reset;
    assign in_mem_phase_s   = (state_r == FETCH) || (state_r == MEM);
    assign timed_out_s      = in_mem_phase_s && !Mem_ready && timer_expired_s;

    // Any state change restarts the wait count for the next request phase.
    assign timer_clear_s  = (state_next_s != state_r);
    assign timer_enable_s = En && in_mem_phase_s && !Mem_ready;

    ctrl_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wait_timer (
        .clk    (Clk),
        .reset  (Reset),
        .clear  (timer_clear_s),
        .enable (timer_enable_s),
        .expired(timer_expired_s)
    );

    // State, latched opcode and sticky bus error.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r     <= FETCH;
            op_q_r      <= OP_NOP;
            bus_error_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (En && (state_r == DECODE)) begin
                op_q_r <= opcode_illegal_s ? OP_NOP : opcode_low_s;
            end else begin
                op_q_r <= op_q_r;
            end
            if (En && timed_out_s) begin
                bus_error_r <= 1'b1;
            end else begin
                bus_error_r <= bus_error_r;
            end
        end
    end

    // Next-state decode; En low freezes the sequence.
    always_comb begin
        state_next_s = state_r;
        if (En) begin
            case (state_r)
                FETCH: begin
                    if (Mem_ready)        state_next_s = DECODE;
                    else if (timed_out_s) state_next_s = HALT;
                    else                  state_next_s = FETCH;
                end
                DECODE: begin
                    if (opcode_illegal_s || (opcode_low_s == OP_NOP)) state_next_s = FETCH;
                    else if (opcode_low_s == OP_HALT)                 state_next_s = HALT;
                    else                                              state_next_s = EXEC;
                end
                EXEC: begin
                    case (op_q_r)
                        OP_ADD, OP_SUB, OP_AND: state_next_s = WB;
                        OP_LOAD, OP_STORE:      state_next_s = MEM;
                        default:                state_next_s = FETCH;
                    endcase
                end
                MEM: begin
                    if (Mem_ready)        state_next_s = (op_q_r == OP_STORE) ? FETCH : WB;
                    else if (timed_out_s) state_next_s = HALT;
                    else                  state_next_s = MEM;
                end
                WB:      state_next_s = FETCH;
                HALT:    state_next_s = HALT;
                default: state_next_s = FETCH;
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // Strobes are decoded from state and latched opcode, suppressed under Reset or En low.
    always_comb begin
        Mem_req      = 1'b0;
        Ir_load      = 1'b0;
        Pc_inc       = 1'b0;
        Pc_load      = 1'b0;
        En_write_reg = 1'b0;
        En_write_mem = 1'b0;
        Illegal_op   = 1'b0;
        alu_s        = ALU_ADD;
        case (state_r)
            FETCH: begin
                Mem_req = run_s;
                Ir_load = run_s && Mem_ready;
                Pc_inc  = run_s && Mem_ready;
            end
            DECODE: begin
                Illegal_op = run_s && opcode_illegal_s;
            end
            EXEC: begin
                alu_s   = alu_sel(op_q_r);
                Pc_load = run_s && (op_q_r == OP_JMP);
            end
            MEM: begin
                alu_s        = ALU_PASS;
                Mem_req      = run_s;
                En_write_mem = run_s && (op_q_r == OP_STORE);
            end
            WB: begin
                alu_s        = alu_sel(op_q_r);
                En_write_reg = run_s;
            end
            default: begin
                alu_s = ALU_ADD;
            end
        endcase
    end

    assign ALU_OP    = ALU_OP_W'(alu_s);
    assign Halted    = (state_r == HALT);
    assign Bus_error = bus_error_r;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: an instruction-level model expands each instruction
// into per-cycle expected outputs, compared against the control unit.
module tb_multicycle_control_unit;

    localparam int MEM_TIMEOUT = 15;

    localparam logic [6:0] F_MREQ = 7'b1000000;
    localparam logic [6:0] F_IR   = 7'b0100000;
    localparam logic [6:0] F_PCI  = 7'b0010000;
    localparam logic [6:0] F_PCL  = 7'b0001000;
    localparam logic [6:0] F_WREG = 7'b0000100;
    localparam logic [6:0] F_WMEM = 7'b0000010;
    localparam logic [6:0] F_ILL  = 7'b0000001;

    typedef struct packed {
        logic        rst;
        logic        en;
        logic        rdy;
        logic [3:0]  op;
        logic [11:0] exp;
    } cyc_t;

    logic       Clk;
    logic       Reset;
    logic       En;
    logic [3:0] Opcode;
    logic       Mem_ready;
    logic       Mem_req, Ir_load, Pc_inc, Pc_load, En_write_reg, En_write_mem;
    logic [2:0] ALU_OP;
    logic       Halted, Illegal_op, Bus_error;
    logic [11:0] obs;

    int   checks   = 0;
    int   failures = 0;
    int   step     = 0;
    cyc_t q[$];
    logic m_halted = 1'b0;
    logic m_bus    = 1'b0;
    logic stall_on = 1'b0;

    multicycle_control_unit #(
        .OPCODE_W(4), .ALU_OP_W(3), .MEM_TIMEOUT(MEM_TIMEOUT)
    ) dut (
        .Clk(Clk), .Reset(Reset), .En(En), .Opcode(Opcode), .Mem_ready(Mem_ready),
        .Mem_req(Mem_req), .Ir_load(Ir_load), .Pc_inc(Pc_inc), .Pc_load(Pc_load),
        .En_write_reg(En_write_reg), .En_write_mem(En_write_mem), .ALU_OP(ALU_OP),
        .Halted(Halted), .Illegal_op(Illegal_op), .Bus_error(Bus_error)
    );

    assign obs = {ALU_OP, Mem_req, Ir_load, Pc_inc, Pc_load, En_write_reg,
                  En_write_mem, Illegal_op, Halted, Bus_error};

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [2:0] alu_of(input logic [2:0] code);
        case (code)
            3'd1:       return 3'd0;
            3'd2:       return 3'd1;
            3'd3:       return 3'd2;
            3'd4, 3'd5: return 3'd3;
            default:    return 3'd0;
        endcase
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [3:0] rnd_op();
        return 4'($urandom_range(0, 15));
    endfunction

    // One enabled cycle, optionally preceded by random frozen (En=0) cycles.
    task automatic push(input logic rdy, input logic [3:0] op, input logic [2:0] alu,
                        input logic [6:0] fl);
        cyc_t c;
        int   s;
        s = (stall_on && ($urandom_range(0, 3) == 0)) ? int'($urandom_range(1, 3)) : 0;
        for (int i = 0; i < s; i++) begin
            c = '{1'b0, 1'b0, rnd_bit(), rnd_op(), {alu, 7'b0, m_halted, m_bus}};
            q.push_back(c);
        end
        c = '{1'b0, 1'b1, rdy, op, {alu, fl, m_halted, m_bus}};
        q.push_back(c);
    endtask

    task automatic push_reset(input logic [2:0] alu);
        cyc_t c;
        c = '{1'b1, rnd_bit(), rnd_bit(), rnd_op(), {alu, 7'b0, m_halted, m_bus}};
        q.push_back(c);
        m_halted = 1'b0;
        m_bus    = 1'b0;
    endtask

    task automatic push_halt_cycles(input int n);
        for (int i = 0; i < n; i++) push(rnd_bit(), rnd_op(), 3'd0, 7'd0);
    endtask

    // A memory handshake phase: 'waits' not-ready cycles, then ready; too many waits is a bus error.
    task automatic mem_phase(input int waits, input logic [6:0] fl_wait, input logic [6:0] fl_ack,
                             input logic [2:0] alu, output logic ok);
        ok = 1'b0;
        for (int i = 0; i <= MEM_TIMEOUT; i++) begin
            if (i == waits) begin
                push(1'b1, rnd_op(), alu, fl_ack);
                ok = 1'b1;
                return;
            end
            push(1'b0, rnd_op(), alu, fl_wait);
        end
        m_bus    = 1'b1;
        m_halted = 1'b1;
    endtask

    task automatic model_instr(input logic [3:0] opc, input int fw, input int mw);
        logic       ok;
        logic [2:0] code;
        logic [2:0] alu;
        code = opc[2:0];
        alu  = alu_of(code);
        mem_phase(fw, F_MREQ, F_MREQ | F_IR | F_PCI, 3'd0, ok);
        if (!ok) return;
        push(rnd_bit(), opc, 3'd0, opc[3] ? F_ILL : 7'd0);
        if (opc[3] || code == 3'd0) return;
        if (code == 3'd7) begin
            m_halted = 1'b1;
            return;
        end
        push(rnd_bit(), rnd_op(), alu, (code == 3'd6) ? F_PCL : 7'd0);
        if (code == 3'd6) return;
        if (code == 3'd4 || code == 3'd5) begin
            mem_phase(mw, F_MREQ | ((code == 3'd5) ? F_WMEM : 7'd0),
                      F_MREQ | ((code == 3'd5) ? F_WMEM : 7'd0), 3'd3, ok);
            if (!ok || code == 3'd5) return;
        end
        push(rnd_bit(), rnd_op(), alu, F_WREG);
    endtask

    task automatic test_reset();
        cyc_t c;
        @(negedge Clk);
        Reset = 1'b1; En = 1'b0; Mem_ready = 1'b1; Opcode = 4'd1;
        @(negedge Clk);
        En = 1'b1;
        #2;
        checks++;
        if (obs !== 12'h000) begin
            failures++;
            $display("FAIL reset_state got=%h expected=%h", obs, 12'h000);
        end
        stall_on = 1'b0;
        push_reset(3'd0);
        model_instr(4'd0, 0, 0);
        model_instr(4'd0, 2, 0);
        while (q.size() > 0) begin
            c = q.pop_front();
            @(negedge Clk);
            Reset = c.rst; En = c.en; Mem_ready = c.rdy; Opcode = c.op;
            #2;
            checks++;
            if (obs !== c.exp) begin
                failures++;
                $display("FAIL reset_seq step=%0d got=%h expected=%h", step, obs, c.exp);
            end
            step++;
        end
    endtask

    task automatic test_alu_back_to_back();
        cyc_t c;
        stall_on = 1'b0;
        for (int i = 0; i < 3; i++) model_instr(4'd1, 0, 0);
        model_instr(4'd2, 0, 0);
        model_instr(4'd3, 1, 0);
        while (q.size() > 0) begin
            c = q.pop_front();
            @(negedge Clk);
            Reset = c.rst; En = c.en; Mem_ready = c.rdy; Opcode = c.op;
            #2;
            checks++;
            if (obs !== c.exp) begin
                failures++;
                $display("FAIL alu_b2b step=%0d got=%h expected=%h", step, obs, c.exp);
            end
            step++;
        end
    endtask

    task automatic test_mem_and_jump();
        cyc_t c;
        stall_on = 1'b0;
        model_instr(4'd5, 0, 3);
        model_instr(4'd4, 0, 0);
        model_instr(4'd4, 1, 2);
        model_instr(4'd6, 0, 0);
        model_instr(4'd5, 0, MEM_TIMEOUT);
        while (q.size() > 0) begin
            c = q.pop_front();
            @(negedge Clk);
            Reset = c.rst; En = c.en; Mem_ready = c.rdy; Opcode = c.op;
            #2;
            checks++;
            if (obs !== c.exp) begin
                failures++;
                $display("FAIL mem_jmp step=%0d got=%h expected=%h", step, obs, c.exp);
            end
            step++;
        end
    endtask

    task automatic test_random_program();
        cyc_t       c;
        logic [3:0] op;
        stall_on = 1'b1;
        for (int i = 0; i < 60; i++) begin
            op[2:0] = 3'($urandom_range(0, 6));
            op[3]   = ($urandom_range(0, 3) == 0);
            model_instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 4)));
        end
        stall_on = 1'b0;
        while (q.size() > 0) begin
            c = q.pop_front();
            @(negedge Clk);
            Reset = c.rst; En = c.en; Mem_ready = c.rdy; Opcode = c.op;
            #2;
            checks++;
            if (obs !== c.exp) begin
                failures++;
                $display("FAIL random_prog step=%0d got=%h expected=%h", step, obs, c.exp);
            end
            step++;
        end
    endtask

    task automatic test_halt_and_illegal();
        cyc_t c;
        stall_on = 1'b0;
        model_instr(4'b1001, 0, 0);
        model_instr(4'b1111, 0, 0);
        model_instr(4'd7, 0, 0);
        stall_on = 1'b1;
        push_halt_cycles(8);
        stall_on = 1'b0;
        push_reset(3'd0);
        model_instr(4'd1, 0, 0);
        while (q.size() > 0) begin
            c = q.pop_front();
            @(negedge Clk);
            Reset = c.rst; En = c.en; Mem_ready = c.rdy; Opcode = c.op;
            #2;
            checks++;
            if (obs !== c.exp) begin
                failures++;
                $display("FAIL halt_illegal step=%0d got=%h expected=%h", step, obs, c.exp);
            end
            step++;
        end
    endtask

    task automatic test_timeout_and_abort();
        cyc_t c;
        int   n;
        stall_on = 1'b0;
        model_instr(4'd4, 0, 99);
        push_halt_cycles(4);
        push_reset(3'd0);
        model_instr(4'd0, 99, 0);
        push_halt_cycles(3);
        push_reset(3'd0);
        n = q.size();
        model_instr(4'd5, 0, 8);
        q = q[0:n+5];
        push_reset(3'd3);
        model_instr(4'd1, 0, 0);
        while (q.size() > 0) begin
            c = q.pop_front();
            @(negedge Clk);
            Reset = c.rst; En = c.en; Mem_ready = c.rdy; Opcode = c.op;
            #2;
            checks++;
            if (obs !== c.exp) begin
                failures++;
                $display("FAIL timeout_abort step=%0d got=%h expected=%h", step, obs, c.exp);
            end
            step++;
        end
    endtask

    initial begin
        Reset = 1'b1; En = 1'b0; Mem_ready = 1'b0; Opcode = 4'd0;
        test_reset();
        test_alu_back_to_back();
        test_mem_and_jump();
        test_random_program();
        test_halt_and_illegal();
        test_timeout_and_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
